// File: rtl/exe_stage_mc_pkg.sv
// exe_stage_mc shared types
// ALU codes, mul/div ops, FSM states, opcodes
package exe_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_LUI  = 5'd10,
        ALU_BEQ  = 5'd16,
        ALU_BNE  = 5'd17,
        ALU_BLT  = 5'd18,
        ALU_BGE  = 5'd19,
        ALU_BLTU = 5'd20,
        ALU_BGEU = 5'd21
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // branch compare codes live in the upper half of the ctrl space
    function automatic logic is_branch(input logic [4:0] c);
        return c[4];
    endfunction

endpackage

// File: rtl/exe_stage_mc_if.sv
// exe_stage_mc pipeline-side bundle
// master drives EX inputs, slave is the execute stage
interface exe_stage_mc_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            E_valid;
    logic [XLEN-1:0] E_pc;
    logic [XLEN-1:0] E_imm;
    logic [REGW-1:0] E_rs1;
    logic [REGW-1:0] E_rs2;
    logic [REGW-1:0] E_rd;
    logic [XLEN-1:0] E_rs1_data;
    logic [XLEN-1:0] E_rs2_data;
    logic [REGW-1:0] M_rd;
    logic [REGW-1:0] W_rd;
    logic            M_reg_write_enable;
    logic            W_reg_write_enable;
    logic [XLEN-1:0] M_rd_data;
    logic [XLEN-1:0] W_rd_data;
    logic            E_alu_op1_sel;
    logic            E_alu_op2_sel;
    logic [4:0]      E_alu_ctrl;
    logic            E_md_en;
    logic [2:0]      E_md_op;
    logic            E_JAL;
    logic            E_JALR;
    logic [6:0]      E_op;
    logic [REGW-1:0] D_rs1;
    logic [REGW-1:0] D_rs2;
    logic            stall;
    logic            flush;
    logic            next_pc_sel;
    logic [XLEN-1:0] jb_pc;
    logic [XLEN-1:0] E_alu_out;
    logic [XLEN-1:0] E_DM_data;
    logic            md_busy;

    modport master (
        output E_valid, E_pc, E_imm, E_rs1, E_rs2, E_rd,
        output E_rs1_data, E_rs2_data, M_rd, W_rd,
        output M_reg_write_enable, W_reg_write_enable,
        output M_rd_data, W_rd_data, E_alu_op1_sel,
        output E_alu_op2_sel, E_alu_ctrl, E_md_en, E_md_op,
        output E_JAL, E_JALR, E_op, D_rs1, D_rs2,
        input  stall, flush, next_pc_sel, jb_pc,
        input  E_alu_out, E_DM_data, md_busy
    );

    modport slave (
        input  E_valid, E_pc, E_imm, E_rs1, E_rs2, E_rd,
        input  E_rs1_data, E_rs2_data, M_rd, W_rd,
        input  M_reg_write_enable, W_reg_write_enable,
        input  M_rd_data, W_rd_data, E_alu_op1_sel,
        input  E_alu_op2_sel, E_alu_ctrl, E_md_en, E_md_op,
        input  E_JAL, E_JALR, E_op, D_rs1, D_rs2,
        output stall, flush, next_pc_sel, jb_pc,
        output E_alu_out, E_DM_data, md_busy
    );
endinterface

// File: rtl/exe_stage_mc_muldiv.sv
// Iterative M-extension engine, one bit per cycle
// shift-add multiply / restoring divide on magnitudes
module muldiv_iter
    import exe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state;
    md_state_e       state_nx;
    md_op_e          op_e;
    md_op_e          op_q;
    logic [CW-1:0]   cnt;
    logic            neg_a_q;
    logic            neg_b_q;
    logic            fixed_q;
    logic [XLEN-1:0] mag_b_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    logic            is_div;
    logic            sgn_a;
    logic            sgn_b;
    logic            neg_a;
    logic            neg_b;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    logic [XLEN:0]   add_s;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_sub;
    logic            q_bit;
    logic [XLEN-1:0] mul_hi;
    logic [XLEN-1:0] mul_lo;
    logic [XLEN-1:0] div_hi;
    logic [XLEN-1:0] div_lo;

    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    assign op_e = md_op_e'(op);

    // operand signs, magnitudes and the two divide shortcuts
    always_comb begin
        is_div   = op[2];
        sgn_a    = op_e inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
        sgn_b    = op_e inside {MD_MULH, MD_DIV, MD_REM};
        neg_a    = sgn_a & a[XLEN-1];
        neg_b    = sgn_b & b[XLEN-1];
        mag_a    = neg_a ? -a : a;
        mag_b    = neg_b ? -b : b;
        div_zero = is_div & (b == '0);
        div_ovf  = is_div & sgn_b & (a == MIN) & (b == '1);
    end

    // one iteration step for each algorithm
    always_comb begin
        add_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_b_q} : '0);
        mul_hi  = add_s[XLEN:1];
        mul_lo  = {add_s[0], lo_q[XLEN-1:1]};
        rem_sh  = {hi_q, lo_q[XLEN-1]};
        rem_sub = rem_sh - {1'b0, mag_b_q};
        q_bit   = ~rem_sub[XLEN];
        div_hi  = q_bit ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
        div_lo  = {lo_q[XLEN-2:0], q_bit};
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= state_nx;
    end

    // FSM next state; shortcuts skip the iteration
    always_comb begin
        state_nx = state;
        unique case (state)
            MD_IDLE: if (start)
                state_nx = (div_zero | div_ovf) ? MD_DONE : MD_BUSY;
            MD_BUSY: if (cnt == '0) state_nx = MD_DONE;
            MD_DONE: state_nx = MD_IDLE;
            default: state_nx = MD_IDLE;
        endcase
    end

    // latch operands at start, iterate while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q    <= MD_MUL;
            cnt     <= '0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
            fixed_q <= 1'b0;
            mag_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            unique case (state)
                MD_IDLE: if (start) begin
                    op_q    <= op_e;
                    cnt     <= CW'(XLEN - 1);
                    neg_a_q <= neg_a;
                    neg_b_q <= neg_b;
                    fixed_q <= div_zero | div_ovf;
                    mag_b_q <= mag_b;
                    if (div_zero) begin
                        lo_q <= '1;
                        hi_q <= a;
                    end else if (div_ovf) begin
                        lo_q <= MIN;
                        hi_q <= '0;
                    end else begin
                        lo_q <= mag_a;
                        hi_q <= '0;
                    end
                end
                MD_BUSY: begin
                    cnt <= cnt - CW'(1);
                    if (op_q[2]) begin
                        hi_q <= div_hi;
                        lo_q <= div_lo;
                    end else begin
                        hi_q <= mul_hi;
                        lo_q <= mul_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs: status flags and combinational sign fix-up
    always_comb begin
        busy   = (state != MD_IDLE);
        done   = (state == MD_DONE);
        prod   = {hi_q, lo_q};
        prod_s = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo    = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        rem    = neg_a_q ? -hi_q : hi_q;
        result = '0;
        if (fixed_q) begin
            result = op_q[1] ? hi_q : lo_q;
        end else begin
            unique case (op_q)
                MD_MUL:                       result = prod_s[XLEN-1:0];
                MD_MULH, MD_MULHSU, MD_MULHU: result = prod_s[2*XLEN-1:XLEN];
                MD_DIV, MD_DIVU:              result = quo;
                MD_REM, MD_REMU:              result = rem;
                default:                      result = '0;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: ALU, forwarding, branches,
// load-use detection and iterative mul/div with stall
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input logic          clk,
    input logic          rst,
    exe_stage_mc_if.slave bus
);

    localparam int SHW = $clog2(XLEN);

    logic [REGW-1:0] rs_idx  [2];
    logic [XLEN-1:0] rf_data [2];
    logic [XLEN-1:0] fwd     [2];

    assign rs_idx[0]  = bus.E_rs1;
    assign rs_idx[1]  = bus.E_rs2;
    assign rf_data[0] = bus.E_rs1_data;
    assign rf_data[1] = bus.E_rs2_data;

    for (genvar i = 0; i < 2; i++) begin : g_fwd
        logic m_hit;
        logic w_hit;
        assign m_hit = bus.M_reg_write_enable & (bus.M_rd != '0)
                     & (bus.M_rd == rs_idx[i]);
        assign w_hit = bus.W_reg_write_enable & (bus.W_rd != '0)
                     & (bus.W_rd == rs_idx[i]);
        assign fwd[i] = m_hit ? bus.M_rd_data
                      : w_hit ? bus.W_rd_data
                      : rf_data[i];
    end

    alu_ctrl_e       ctrl;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [SHW-1:0]  shamt;
    logic            eq;
    logic            lt;
    logic            ltu;
    logic            pc_flag;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] jb_sum;

    logic            lu_hz;
    logic            start;
    logic            md_busy;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    assign ctrl  = alu_ctrl_e'(bus.E_alu_ctrl);
    assign op1   = bus.E_alu_op1_sel ? bus.E_pc : fwd[0];
    assign op2   = bus.E_alu_op2_sel ? bus.E_imm : fwd[1];
    assign shamt = op2[SHW-1:0];
    assign eq    = (op1 == op2);
    assign lt    = ($signed(op1) < $signed(op2));
    assign ltu   = (op1 < op2);

    // single-cycle ALU and branch compare
    always_comb begin
        alu_res = '0;
        pc_flag = 1'b0;
        unique case (ctrl)
            ALU_ADD:  alu_res = op1 + op2;
            ALU_SUB:  alu_res = op1 - op2;
            ALU_SLL:  alu_res = op1 << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, ltu};
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_SRL:  alu_res = op1 >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(op1) >>> shamt);
            ALU_OR:   alu_res = op1 | op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_LUI:  alu_res = op2;
            ALU_BEQ:  pc_flag = eq;
            ALU_BNE:  pc_flag = ~eq;
            ALU_BLT:  pc_flag = lt;
            ALU_BGE:  pc_flag = ~lt;
            ALU_BLTU: pc_flag = ltu;
            ALU_BGEU: pc_flag = ~ltu;
            default:  alu_res = '0;
        endcase
        if (is_branch(bus.E_alu_ctrl))
            alu_res = {{(XLEN-1){1'b0}}, pc_flag};
    end

    assign start = bus.E_valid & bus.E_md_en;

    muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (bus.E_md_op),
        .a      (fwd[0]),
        .b      (fwd[1]),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    // hazards, redirect and result selection
    always_comb begin
        lu_hz = bus.E_valid & (bus.E_op == OP_LOAD)
              & (bus.E_rd != '0)
              & ((bus.E_rd == bus.D_rs1) | (bus.E_rd == bus.D_rs2));
        jb_sum = (bus.E_JALR ? fwd[0] : bus.E_pc) + bus.E_imm;
        bus.jb_pc = {jb_sum[XLEN-1:1], jb_sum[0] & ~bus.E_JALR};
        bus.flush = bus.E_valid & ~bus.E_md_en
                  & (pc_flag | bus.E_JAL | bus.E_JALR);
        bus.next_pc_sel = bus.flush;
        bus.stall = lu_hz | (~md_busy & start) | (md_busy & ~md_done);
        bus.md_busy = md_busy;
        bus.E_alu_out = md_done ? md_result : alu_res;
        bus.E_DM_data = fwd[1];
    end

endmodule
